// File: rtl/adpcm_pcm_mux_arbiter_if.sv
// adpcm_pcm_mux_arbiter_if
//   Bundles every signal around the PCM mux / YM IO nybble-bus arbiter:
//   - ADPCM-A reader side: a_mux_needed, a_ym_io_out/en, a_mux_sel, a_mux_oe_n,
//     a_pcm_load in; a_pause out.
//   - ADPCM-B reader side: b_req, b_ym_io_out/en, b_mux_sel, b_mux_oe_n,
//     b_pcm_load in; b_grant out.
//   - Board-level bus: ym_io_out, ym_io_en, mux_sel, mux_oe_n, pcm_load out.
//   - Status: preempt_count, b_timeout out; count_reset in.
//   Modport slave is the arbiter's view; modport master is the view of
//   whoever drives the reader inputs and observes the bus.
interface adpcm_pcm_mux_arbiter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   a_mux_needed;
  logic [3:0]             a_ym_io_out;
  logic                   a_ym_io_en;
  logic [2:0]             a_mux_sel;
  logic                   a_mux_oe_n;
  logic                   a_pcm_load;
  logic                   a_pause;

  logic                   b_req;
  logic [3:0]             b_ym_io_out;
  logic                   b_ym_io_en;
  logic [2:0]             b_mux_sel;
  logic                   b_mux_oe_n;
  logic                   b_pcm_load;
  logic                   b_grant;

  logic [3:0]             ym_io_out;
  logic                   ym_io_en;
  logic [2:0]             mux_sel;
  logic                   mux_oe_n;
  logic                   pcm_load;

  logic [COUNT_WIDTH-1:0] preempt_count;
  logic                   b_timeout;
  logic                   count_reset;

  modport slave (
    input  a_mux_needed, a_ym_io_out, a_ym_io_en, a_mux_sel, a_mux_oe_n, a_pcm_load,
    input  b_req, b_ym_io_out, b_ym_io_en, b_mux_sel, b_mux_oe_n, b_pcm_load,
    input  count_reset,
    output a_pause, b_grant,
    output ym_io_out, ym_io_en, mux_sel, mux_oe_n, pcm_load,
    output preempt_count, b_timeout
  );

  modport master (
    output a_mux_needed, a_ym_io_out, a_ym_io_en, a_mux_sel, a_mux_oe_n, a_pcm_load,
    output b_req, b_ym_io_out, b_ym_io_en, b_mux_sel, b_mux_oe_n, b_pcm_load,
    output count_reset,
    input  a_pause, b_grant,
    input  ym_io_out, ym_io_en, mux_sel, mux_oe_n, pcm_load,
    input  preempt_count, b_timeout
  );
endinterface

// File: rtl/adpcm_pcm_mux_arbiter.sv
// adpcm_pcm_mux_arbiter
//   Shares the single PCM mux / YM IO nybble bus between the ADPCM-A reader
//   (interruptible via a_pause) and the ADPCM-B reader (atomic once granted,
//   higher priority). A is preempted, the bus idles for GUARD_CYCLES, B is
//   granted, and the bus idles again for GUARD_CYCLES after B lets go.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     io     adpcm_pcm_mux_arbiter_if.slave (reader inputs, a_pause, b_grant,
//            board bus outputs, preempt_count, b_timeout, count_reset)
module adpcm_pcm_mux_arbiter #(
  parameter int GUARD_CYCLES = 2,
  parameter int B_MAX_HOLD   = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  adpcm_pcm_mux_arbiter_if.slave   io
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int HW = $clog2(B_MAX_HOLD + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(B_MAX_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    A_OWN,
    GUARD_TO_B,
    B_OWN,
    GUARD_TO_A
  } state_t;

  state_t                 state, next_state;
  logic [GW-1:0]          guard_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   b_block;
  logic                   b_req_ok;
  logic                   preempt;
  logic                   timeout;
  logic                   a_pause_q;
  logic                   b_grant_q;
  logic                   b_timeout_q;
  logic [COUNT_WIDTH-1:0] preempt_count_q;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + COUNT_WIDTH'(1);
  endfunction

  // After a forced revoke B is ignored until IDLE has seen b_req low once,
  // so a B reader that keeps requesting cannot immediately re-acquire.
  assign b_req_ok = io.b_req & ~b_block;

  always_comb begin
    next_state = state;
    preempt    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (b_req_ok)             next_state = GUARD_TO_B;
        else if (io.a_mux_needed) next_state = A_OWN;
      end
      A_OWN: begin
        if (b_req_ok) begin
          next_state = GUARD_TO_B;
          preempt    = 1'b1;
        end else if (!io.a_mux_needed) begin
          next_state = IDLE;
        end
      end
      GUARD_TO_B: begin
        if (!io.b_req)                  next_state = IDLE;
        else if (guard_cnt == GUARD_LAST) next_state = B_OWN;
      end
      B_OWN: begin
        if (!io.b_req) begin
          next_state = GUARD_TO_A;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state = GUARD_TO_A;
          timeout    = 1'b1;
        end
      end
      GUARD_TO_A: begin
        if (guard_cnt == GUARD_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus forwarding is purely a function of the registered state, so an async
  // reset drops the bus straight to idle values without passing through B.
  always_comb begin
    io.ym_io_out = 4'h0;
    io.ym_io_en  = 1'b0;
    io.mux_sel   = 3'd0;
    io.mux_oe_n  = 1'b1;
    io.pcm_load  = 1'b0;
    if (state == A_OWN) begin
      io.ym_io_out = io.a_ym_io_out;
      io.ym_io_en  = io.a_ym_io_en;
      io.mux_sel   = io.a_mux_sel;
      io.mux_oe_n  = io.a_mux_oe_n;
      io.pcm_load  = io.a_pcm_load;
    end else if (state == B_OWN) begin
      io.ym_io_out = io.b_ym_io_out;
      io.ym_io_en  = io.b_ym_io_en;
      io.mux_sel   = io.b_mux_sel;
      io.mux_oe_n  = io.b_mux_oe_n;
      io.pcm_load  = io.b_pcm_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      guard_cnt       <= '0;
      hold_cnt        <= '0;
      b_block         <= 1'b0;
      a_pause_q       <= 1'b0;
      b_grant_q       <= 1'b0;
      preempt_count_q <= '0;
      b_timeout_q     <= 1'b0;
    end else begin
      state <= next_state;

      // Both counters restart on every state change and only advance while
      // dwelling in the state they time.
      if (next_state != state)
        guard_cnt <= '0;
      else if (state == GUARD_TO_B || state == GUARD_TO_A)
        guard_cnt <= guard_cnt + GW'(1);

      if (next_state != state)
        hold_cnt <= '0;
      else if (state == B_OWN)
        hold_cnt <= hold_cnt + HW'(1);

      if (timeout)
        b_block <= 1'b1;
      else if (state == IDLE && !io.b_req)
        b_block <= 1'b0;

      a_pause_q <= (next_state == GUARD_TO_B) || (next_state == B_OWN) ||
                   (next_state == GUARD_TO_A);
      b_grant_q <= (next_state == B_OWN);

      if (io.count_reset) begin
        preempt_count_q <= '0;
        b_timeout_q     <= 1'b0;
      end else begin
        if (preempt) preempt_count_q <= sat_inc(preempt_count_q);
        if (timeout) b_timeout_q     <= 1'b1;
      end
    end
  end

  assign io.a_pause       = a_pause_q;
  assign io.b_grant       = b_grant_q;
  assign io.preempt_count = preempt_count_q;
  assign io.b_timeout     = b_timeout_q;

endmodule
